// File: rtl/shift_sequencer_pkg.sv
// Shared constants and state encoding for the serial shift sequencer.
package shift_seq_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

endpackage

// File: rtl/shift_sequencer_if.sv
// Parallel/serial transaction bus between a controller and shift_sequencer.
interface shift_sequencer_if
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             START;
    logic [WIDTH-1:0] DIN;
    logic             SIN;
    logic             SOUT;
    logic             SOUT_VALID;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] DOUT;

    modport master (
        output START, DIN, SIN,
        input  SOUT, SOUT_VALID, BUSY, DONE, DOUT
    );

    modport slave (
        input  START, DIN, SIN,
        output SOUT, SOUT_VALID, BUSY, DONE, DOUT
    );
endinterface

// File: rtl/shift_sequencer_dff_chain.sv
// Gate-level style shift chain: one dff cell per bit behind a load/shift mux.
module dff (
    input  logic CLK,
    input  logic RST,
    input  logic D,
    output logic Q
);
    always_ff @(posedge CLK) begin
        if (RST) Q <= 1'b0;
        else     Q <= D;
    end
endmodule

module dff_chain #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LD,
    input  logic             SH,
    input  logic [WIDTH-1:0] DIN,
    input  logic             SIN,
    output logic [WIDTH-1:0] Q
);
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] d;

    assign shifted = {Q[WIDTH-2:0], SIN};

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            // Load wins over shift; with neither asserted the cell recirculates.
            assign d[i] = LD ? DIN[i] : (SH ? shifted[i] : Q[i]);

            dff u_dff (
                .CLK (CLK),
                .RST (RST),
                .D   (d[i]),
                .Q   (Q[i])
            );
        end
    endgenerate
endmodule

// File: rtl/shift_sequencer.sv
// Sequences a WIDTH-bit dff chain: parallel load, MSB-first shift out/in, result capture.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic              CLK,
    input  logic              RST,
    shift_sequencer_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] chain;
    logic             ld, sh;

    dff_chain #(.WIDTH(WIDTH)) u_chain (
        .CLK (CLK),
        .RST (RST),
        .LD  (ld),
        .SH  (sh),
        .DIN (bus.DIN),
        .SIN (bus.SIN),
        .Q   (chain)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        ld      = 1'b0;
        sh      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    ld      = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sh    = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                // Final shift: capture what the chain is about to hold.
                if (cnt_q == CNT_LAST) begin
                    dout_d  = {chain[WIDTH-2:0], bus.SIN};
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.SOUT       = chain[WIDTH-1];
    assign bus.SOUT_VALID = (state_q == ST_SHIFT);
    assign bus.BUSY       = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign bus.DONE       = (state_q == ST_DONE);
    assign bus.DOUT       = dout_q;
endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized scoreboard bench for shift_sequencer (WIDTH=8) plus a WIDTH=2 corner case.
module tb_shift_sequencer;
    localparam int W  = 8;
    localparam int W2 = 2;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    shift_sequencer_if #(.WIDTH(W))  bus ();
    shift_sequencer_if #(.WIDTH(W2)) bus2 ();

    shift_sequencer #(.WIDTH(W))  dut  (.CLK(CLK), .RST(RST), .bus(bus));
    shift_sequencer #(.WIDTH(W2)) dut2 (.CLK(CLK), .RST(RST), .bus(bus2));

    int   cyc = 0;
    logic rst_at_edge = 1'b0;
    always @(posedge CLK) begin
        cyc         <= cyc + 1;
        rst_at_edge <= RST;
    end

    int passed = 0;
    int total  = 0;

    typedef struct {
        int           done_cyc;
        logic [W-1:0] dout;
    } exp_t;

    exp_t     sb[$];
    bit       exp_busy[int];
    bit       exp_sv[int];
    bit       exp_sout[int];
    logic [W-1:0] model_dout = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    endtask

    task automatic flush_model();
        sb.delete();
        exp_busy.delete();
        exp_sv.delete();
        exp_sout.delete();
    endtask

    task automatic idle_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: compares whatever the DUT presents against the expectation tables.
    initial begin
        exp_t e;
        logic eb, ev;
        forever begin
            @(negedge CLK);
            if (rst_at_edge) begin
                model_dout = '0;
                chk("reset_outputs",
                    {bus.BUSY, bus.SOUT_VALID, bus.DONE, bus.SOUT, bus.DOUT}, '0);
            end else begin
                eb = exp_busy.exists(cyc) != 0;
                ev = exp_sv.exists(cyc) != 0;
                chk("busy_valid", {bus.BUSY, bus.SOUT_VALID}, {eb, ev});
                if (bus.SOUT_VALID && ev)
                    chk("sout", bus.SOUT, exp_sout[cyc]);
                if (bus.DONE) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("done_cycle", cyc, e.done_cyc);
                        chk("dout", bus.DOUT, e.dout);
                        model_dout = e.dout;
                    end
                end else begin
                    chk("dout_hold", bus.DOUT, model_dout);
                end
                if (sb.size() > 0 && sb[0].done_cyc < cyc) begin
                    chk("missing_done", cyc, sb[0].done_cyc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    // One transaction: START in IDLE, SIN streamed MSB-first on the shift edges.
    // hold keeps START high afterwards; noise toggles START/DIN while busy;
    // rst_after>0 asserts RST once that many shifts have happened.
    task automatic issue(input logic [W-1:0] din, input logic [W-1:0] sin,
                         input bit hold, input bit noise, input int rst_after);
        int   a;
        exp_t e;
        bus.START = 1'b1;
        bus.DIN   = din;
        @(posedge CLK);
        #1;
        a = cyc;
        if (!hold) bus.START = 1'b0;
        for (int i = 0; i < W; i++) begin
            exp_busy[a+i] = 1'b1;
            exp_sv[a+i]   = 1'b1;
            exp_sout[a+i] = din[W-1-i];
        end
        exp_busy[a+W] = 1'b1;
        e.done_cyc = a + W;
        e.dout     = sin;
        sb.push_back(e);
        for (int i = 0; i < W; i++) begin
            bus.SIN = sin[W-1-i];
            if (noise && !hold) begin
                bus.START = 1'($urandom_range(0, 1));
                bus.DIN   = W'($urandom);
            end
            if (rst_after != 0 && i == rst_after) begin
                RST = 1'b1;
                @(posedge CLK);
                #1;
                RST       = 1'b0;
                bus.START = 1'b0;
                flush_model();
                return;
            end
            @(posedge CLK);
            #1;
        end
        // Now in the DONE cycle: a START here must be ignored.
        if (noise && !hold) begin
            bus.START = 1'b1;
            bus.DIN   = W'($urandom);
        end
        @(posedge CLK);
        #1;
        if (!hold) bus.START = 1'b0;
    endtask

    task automatic run_w2();
        bus2.START = 1'b1;
        bus2.DIN   = 2'b10;
        @(posedge CLK);
        #1;
        bus2.START = 1'b0;
        bus2.SIN   = 1'b1;
        @(negedge CLK);
        chk("w2_shift0", {bus2.SOUT_VALID, bus2.SOUT, bus2.DONE}, 3'b110);
        @(posedge CLK);
        #1;
        bus2.SIN = 1'b1;
        @(negedge CLK);
        chk("w2_shift1", {bus2.SOUT_VALID, bus2.SOUT, bus2.DONE}, 3'b100);
        @(posedge CLK);
        #1;
        bus2.SIN = 1'b0;
        @(negedge CLK);
        chk("w2_done", {bus2.DONE, bus2.BUSY, bus2.SOUT_VALID, bus2.DOUT}, 5'b11011);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("w2_hold", {bus2.DONE, bus2.BUSY, bus2.DOUT}, 4'b0011);
    endtask

    initial begin
        RST        = 1'b1;
        bus.START  = 1'b0;
        bus.DIN    = '0;
        bus.SIN    = 1'b0;
        bus2.START = 1'b0;
        bus2.DIN   = '0;
        bus2.SIN   = 1'b0;
        repeat (3) idle_cycle();
        RST = 1'b0;
        idle_cycle();

        issue(8'hA5, 8'h3C, 1'b0, 1'b0, 0);
        repeat (2) idle_cycle();

        for (int n = 0; n < 3; n++) issue(8'hFF, 8'h00, 1'b1, 1'b0, 0);
        bus.START = 1'b0;
        repeat (2) idle_cycle();

        issue(W'($urandom), W'($urandom), 1'b0, 1'b1, 0);
        repeat (3) idle_cycle();

        for (int n = 0; n < 20; n++) begin
            issue(W'($urandom), W'($urandom), 1'b0, 1'($urandom_range(0, 1)), 0);
            repeat ($urandom_range(0, 3)) idle_cycle();
        end

        issue(W'($urandom), 8'h3C, 1'b0, 1'b0, 4);
        issue(8'h81, W'($urandom), 1'b0, 1'b0, 0);
        repeat (2) idle_cycle();

        RST       = 1'b1;
        bus.START = 1'b1;
        bus.DIN   = W'($urandom);
        idle_cycle();
        RST       = 1'b0;
        bus.START = 1'b0;
        flush_model();
        repeat (3) idle_cycle();

        run_w2();
        repeat (3) idle_cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Serial transaction controller for a `WIDTH`-bit chain of `dff` cells. It loads a parallel word into the chain and shifts it out MSB-first on `SOUT`, while shifting `SIN` in on the same edges. After `WIDTH` shifts it presents the received word on `DOUT` and pulses `DONE`. It sits between gate-level register banks and a serial test/config port, and owns all sequencing of the chain.

## Interface
- `WIDTH`, default 8: chain length in bits; legal range ≥ 2.
- `CLK`  in  1  clock; all state changes on the rising edge.
- `RST`  in  1  reset; synchronous, active-high.
- `START`  in  1  transaction request; sampled only in IDLE.
- `DIN`  in  `WIDTH`  parallel word; loaded into the chain on the edge that accepts `START`.
- `SIN`  in  1  serial input; sampled on every SHIFT-state edge.
- `SOUT`  out  1  serial output, equal to chain MSB; meaningful only while `SOUT_VALID` = 1.
- `SOUT_VALID`  out  1  high throughout the SHIFT state.
- `BUSY`  out  1  high in the SHIFT and DONE states.
- `DONE`  out  1  one-cycle pulse in the DONE state.
- `DOUT`  out  `WIDTH`  last received word; holds its value until the next transaction completes.

## Operation
- **States:** IDLE, SHIFT, DONE. Reset state is IDLE.
- **IDLE:**
  - With `START` = 1 at an edge: chain ← `DIN`, `cnt` ← 0, go to SHIFT.
  - With `START` = 0: hold.
- **SHIFT:** on each edge:
  - chain ← {chain[`WIDTH`-2:0], `SIN`}
  - `cnt` ← `cnt` + 1
  - When `cnt` = `WIDTH`-1 at the edge (the final shift), also load `DOUT` ← {chain[`WIDTH`-2:0], `SIN`} and go to DONE.
- **DONE:** one cycle, then unconditionally go to IDLE.
- **START outside IDLE:** ignored in SHIFT and DONE. It is not queued. `DIN` is not sampled.
- **Counter:** `cnt` is $clog2(`WIDTH`) bits wide. It never exceeds `WIDTH`-1, so there is no wrap.
- **Bit ordering:**
  - `DIN`[`WIDTH`-1] appears on `SOUT` first.
  - The first `SIN` bit sampled lands in `DOUT`[`WIDTH`-1].
- **Reset:** with `RST` = 1 at any edge, including mid-SHIFT:
  - state ← IDLE; chain, `cnt`, `DOUT` ← 0.
  - All outputs read 0 on the following cycle.
  - `RST` takes priority over a simultaneous `START`.
  - A partially shifted word is discarded; `DOUT` is not updated from it.

## Timing
- `START` accepted at edge k → SHIFT during cycles k+1 … k+`WIDTH`.
- `SOUT_VALID` = 1 for exactly `WIDTH` cycles.
- `SIN` is sampled at edges k+1 … k+`WIDTH`.
- `DONE` = 1 during cycle k+`WIDTH`+1. `DOUT` is valid from that cycle on.
- `BUSY` = 1 for cycles k+1 … k+`WIDTH`+1.
- Next acceptance is possible at edge k+`WIDTH`+2 at the earliest. With `START` held high, transactions repeat every `WIDTH`+2 cycles.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs.

## Structure
- **Package `shift_seq_pkg`:** state typedef (IDLE, SHIFT, DONE) and the default `WIDTH` constant.
- **Sub-module `dff_chain`** (`WIDTH` parameter):
  - Ports: `CLK`, `RST`, `LD`, `SH`, `DIN`, `SIN`, `Q`.
  - `LD` has priority over `SH`.
  - Built from `dff` cells plus selection gates, so the gate-level flow can time it.
- **Top level (`shift_sequencer`):** holds the FSM, the counter, the `DOUT` register and output decode.

## Test plan
- **Basic transfer** (`WIDTH`=8): `DIN`=0xA5, `START` pulse, `SIN` drives 0x3C MSB-first.
  - `SOUT` = 1,0,1,0,0,1,0,1.
  - `DONE` high exactly 9 cycles after the accepting edge.
  - `DOUT` = 0x3C and held afterwards.
- **START held high** continuously, `DIN`=0xFF, `SIN`=0:
  - `DONE` pulses every 10 cycles.
  - `DOUT` = 0x00.
  - `BUSY` low for exactly one cycle between transactions.
- **START ignored outside IDLE:** extra `START` pulses during SHIFT and in the DONE cycle, with `DIN` changing each time.
  - No restart; `SOUT` sequence unaffected.
  - Next transaction occurs only after a fresh `START` in IDLE.
- **Reset mid-operation:** `RST` asserted after the 4th shift of a 0x3C transfer.
  - Next cycle: `BUSY`=`SOUT_VALID`=`DONE`=0 and `DOUT`=0x00.
  - A following `START` with `DIN`=0x81 completes normally.
- **RST and START in the same cycle:** block remains IDLE and `BUSY` stays 0.
- **Minimum width** (`WIDTH`=2): `DIN`=2'b10, `SIN`=1,1.
  - `SOUT` = 1,0.
  - `DOUT` = 2'b11.
  - `DONE` 3 cycles after acceptance.
